// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared types and width helpers for the data memory bank
package data_memory_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // A latency of 1 still needs a one-bit counter that simply sits at zero.
    function automatic int cnt_w(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/mem_array_be.sv
// rtl/mem_array_be.sv - single-port word array, byte-enabled sync write, comb read
module mem_array_be #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256
) (
    input  logic                       i_clk,
    input  logic                       i_we,
    input  logic [DATA_W/8-1:0]        i_be,
    input  logic [$clog2(DEPTH)-1:0]   i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/data_memory_bank.sv
// rtl/data_memory_bank.sv - latency-programmable byte-enabled memory behind a req/ack handshake
module data_memory_bank
    import data_memory_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    input  logic                  we_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [DATA_W/8-1:0]   be_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  ack_o,
    output logic                  busy_o,
    output logic                  err_o
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = byte_off_w(DATA_W);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_w(LATENCY);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [BE_W-1:0]     r_be;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack;
    logic                r_err;

    logic                w_accept;
    logic                w_complete;
    logic                w_busy;
    logic                w_mem_we;
    logic                w_valid;
    logic [ADDR_W-1:0]   w_word_idx;
    logic [DATA_W-1:0]   w_mem_rdata;

    // Validity is judged on the latched address so later input changes cannot affect it.
    assign w_word_idx = r_addr >> OFF_W;
    assign w_valid    = ((r_addr & OFF_MASK) == '0) && (w_word_idx < ADDR_W'(DEPTH));

    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_i)        w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_cnt == '0)  w_state_nxt = ST_IDLE;
            default:                   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = (r_state == ST_IDLE) && req_i;
        w_complete = (r_state == ST_WAIT) && (r_cnt == '0);
        w_busy     = (r_state == ST_WAIT);
        w_mem_we   = w_complete && w_valid && r_we;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_complete;
            r_err <= w_complete && !w_valid;
            if (w_accept) begin
                r_cnt   <= CNT_W'(LATENCY - 1);
                r_we    <= we_i;
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_be    <= be_i;
            end else if (w_busy && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_complete) begin
                r_rdata <= (w_valid && !r_we) ? w_mem_rdata : '0;
            end
        end
    end

    mem_array_be #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .i_clk   (clk_i),
        .i_we    (w_mem_we),
        .i_be    (r_be),
        .i_addr  (r_addr[OFF_W +: IDX_W]),
        .i_wdata (r_wdata),
        .o_rdata (w_mem_rdata)
    );

    assign rdata_o = r_rdata;
    assign ack_o   = r_ack;
    assign busy_o  = w_busy;
    assign err_o   = r_err;

endmodule

// File: tb/tb_data_memory_bank.sv
// tb/tb_data_memory_bank.sv - bench for data_memory_bank (LATENCY=4 and LATENCY=1 instances)
module tb_data_memory_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [2];
    logic        we    [2];
    logic [31:0] addr  [2];
    logic [31:0] wd    [2];
    logic [3:0]  be    [2];
    logic [31:0] rdata [2];
    logic        ack   [2];
    logic        busy  [2];
    logic        err   [2];

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    data_memory_bank #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(4)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wd[0]), .be_i(be[0]), .rdata_o(rdata[0]), .ack_o(ack[0]),
        .busy_o(busy[0]), .err_o(err[0])
    );

    data_memory_bank #(.DATA_W(32), .DEPTH(256), .ADDR_W(32), .LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wd[1]), .be_i(be[1]), .rdata_o(rdata[1]), .ack_o(ack[1]),
        .busy_o(busy[1]), .err_o(err[1])
    );

    // Reference model: a pending request completes at a fixed edge deadline.
    int          edge_no = 0;
    logic        pend   [2];
    int          due    [2];
    logic        q_we   [2];
    logic [31:0] q_addr [2];
    logic [31:0] q_wd   [2];
    logic [3:0]  q_be   [2];
    logic [31:0] mm     [2][256];
    logic        x_ack  [2];
    logic        x_err  [2];
    logic        x_busy [2];
    logic [31:0] x_rd   [2];

    function automatic int lat(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            pend[i] = 1'b0; x_ack[i] = 1'b0; x_err[i] = 1'b0; x_busy[i] = 1'b0; x_rd[i] = '0;
            for (int w = 0; w < 256; w++) mm[i][w] = '0;
        end
    end

    always @(posedge clk) begin
        edge_no++;
        for (int i = 0; i < 2; i++) begin
            x_ack[i] = 1'b0;
            x_err[i] = 1'b0;
            if (!rst) begin
                pend[i] = 1'b0;
                x_rd[i] = '0;
            end else if (pend[i]) begin
                if (edge_no == due[i]) begin
                    pend[i]  = 1'b0;
                    x_ack[i] = 1'b1;
                    if ((q_addr[i] % 4 != 0) || (q_addr[i] / 4 >= 256)) begin
                        x_err[i] = 1'b1;
                        x_rd[i]  = '0;
                    end else if (q_we[i]) begin
                        for (int b = 0; b < 4; b++)
                            if (q_be[i][b]) mm[i][q_addr[i] / 4][8*b +: 8] = q_wd[i][8*b +: 8];
                        x_rd[i] = '0;
                    end else begin
                        x_rd[i] = mm[i][q_addr[i] / 4];
                    end
                end
            end else if (req[i]) begin
                pend[i]   = 1'b1;
                due[i]    = edge_no + lat(i);
                q_we[i]   = we[i];
                q_addr[i] = addr[i];
                q_wd[i]   = wd[i];
                q_be[i]   = be[i];
            end
            x_busy[i] = pend[i];
        end
    end

    task automatic cmp(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst%0d t=%0t got=%h exp=%h", nm, i, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                cmp("ack",   i, 32'(ack[i]),  32'(x_ack[i]));
                cmp("err",   i, 32'(err[i]),  32'(x_err[i]));
                cmp("busy",  i, 32'(busy[i]), 32'(x_busy[i]));
                cmp("rdata", i, rdata[i], x_rd[i]);
            end
        end
    end

    // Called at a negedge; the request is taken at the following posedge.
    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] b);
        req[i] = 1'b1; we[i] = w; addr[i] = a; wd[i] = d; be[i] = b;
        @(negedge clk);
        req[i] = 1'b0; wd[i] = ~d; addr[i] = a ^ 32'h4; be[i] = ~b; we[i] = ~w;
    endtask

    task automatic wait_ack(input int i, output int n);
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (ack[i]) begin
                n = k;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL ack_timeout inst%0d got=none exp=ack", i);
    endtask

    initial begin
        int n, nb, got, acks;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wd[i] = '0; be[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        cmp("reset_ack",   0, 32'(ack[0]),  32'd0);
        cmp("reset_busy",  0, 32'(busy[0]), 32'd0);
        cmp("reset_rdata", 0, rdata[0],     32'd0);
        rst = 1'b1;
        @(negedge clk);

        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        wait_ack(0, n);
        cmp("t1_latency", 0, n, 32'd4);
        cmp("t1_err", 0, 32'(err[0]), 32'd0);
        issue(0, 1'b0, 32'h10, 32'h0, 4'h0);
        wait_ack(0, n);
        cmp("t1_read", 0, rdata[0], 32'hDEADBEEF);

        issue(0, 1'b1, 32'h10, 32'h11223344, 4'h5);
        wait_ack(0, n);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        wait_ack(0, n);
        cmp("t2_be_read", 0, rdata[0], 32'hDE22BE44);

        issue(0, 1'b0, 32'h400, 32'h0, 4'hF);
        wait_ack(0, n);
        cmp("t3_oor_err", 0, 32'(err[0]), 32'd1);
        cmp("t3_oor_rdata", 0, rdata[0], 32'd0);
        issue(0, 1'b1, 32'h13, 32'hFFFFFFFF, 4'hF);
        wait_ack(0, n);
        cmp("t3_mis_err", 0, 32'(err[0]), 32'd1);
        issue(0, 1'b0, 32'h10, 32'h0, 4'hF);
        wait_ack(0, n);
        cmp("t3_word4", 0, rdata[0], 32'hDE22BE44);
        cmp("t3_err_clear", 0, 32'(err[0]), 32'd0);

        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h40; wd[0] = 32'h12345678; be[0] = 4'hF;
        nb = 0;
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (busy[0]) nb++;
            if (ack[0]) begin
                got = k;
                break;
            end
            req[0] = k[0]; we[0] = 1'b1; addr[0] = 32'h44; wd[0] = 32'hA5A50000 + k;
        end
        cmp("t4_busy_cycles", 0, nb, 32'd4);
        cmp("t4_ack_cycle", 0, got, 32'd5);
        issue(0, 1'b0, 32'h40, 32'h0, 4'hF);
        wait_ack(0, n);
        cmp("t4_reissue_latency", 0, n, 32'd4);
        cmp("t4_first_data", 0, rdata[0], 32'h12345678);
        issue(0, 1'b0, 32'h44, 32'h0, 4'hF);
        wait_ack(0, n);
        cmp("t4_ignored_write", 0, rdata[0], 32'h0);

        issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("t5_rst_ack",   0, 32'(ack[0]),  32'd0);
        cmp("t5_rst_busy",  0, 32'(busy[0]), 32'd0);
        cmp("t5_rst_err",   0, 32'(err[0]),  32'd0);
        cmp("t5_rst_rdata", 0, rdata[0],     32'd0);
        rst = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack[0]) acks++;
        end
        cmp("t5_no_ack", 0, acks, 32'd0);
        issue(0, 1'b0, 32'h20, 32'h0, 4'hF);
        wait_ack(0, n);
        cmp("t5_not_written", 0, rdata[0], 32'h0);

        for (int w = 0; w < 4; w++) begin
            issue(1, 1'b1, 32'(4 * w), 32'hB0B00000 + 32'(w * 17), 4'hF);
            wait_ack(1, n);
            cmp("t6_wr_latency", 1, n, 32'd1);
        end
        for (int w = 0; w < 4; w++) begin
            issue(1, 1'b0, 32'(4 * w), 32'h0, 4'hF);
            wait_ack(1, n);
            cmp("t6_rd_latency", 1, n, 32'd1);
            cmp("t6_rd_data", 1, rdata[1], 32'hB0B00000 + 32'(w * 17));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
